// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU feeding the accumulator; one-clock ops plus
// an iterative shift-add multiply over WIDTH clocks.
// Ports:
//   CLK, RESET         - clock, async active-high reset
//   a, b, op, start    - operands, op select, request (taken when idle)
//   result             - registered result, held until next completion
//   result_valid       - one-cycle completion pulse
//   busy               - high from acceptance until completion
//   carry, zero, negative, overflow - flags of the last completed op
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam int M = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL
    } state_t;

    state_t state, state_next;

    // opa is double width so it can serve as the shifting multiplicand
    logic [2*WIDTH-1:0] opa;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   opb;
    logic [2:0]         op_q;
    logic [CW-1:0]      cnt;

    logic             accept;
    logic             last_mul;
    logic             complete;
    logic [WIDTH-1:0] x;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] done_res;
    logic             done_c;
    logic             done_v;

    assign accept   = (state == IDLE) && start;
    assign last_mul = (state == MUL) && (cnt == CNT_LAST);
    assign complete = (state == EXEC) || last_mul;
    assign busy     = (state != IDLE);
    assign x        = opa[WIDTH-1:0];
    assign acc_sum  = acc + (opb[0] ? opa : '0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (op == 3'b111) ? MUL : EXEC;
                end
            end
            EXEC: state_next = IDLE;
            MUL: begin
                if (last_mul) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op_q)
            3'b000: begin
                wide    = {1'b0, x} + {1'b0, opb};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (x[M] == opb[M]) && (alu_res[M] != x[M]);
            end
            3'b001: begin
                // top bit of the widened difference is the borrow
                wide    = {1'b0, x} - {1'b0, opb};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (x[M] != opb[M]) && (alu_res[M] != x[M]);
            end
            3'b010: alu_res = x & opb;
            3'b011: alu_res = x | opb;
            3'b100: alu_res = x ^ opb;
            3'b101: begin
                alu_res = {x[WIDTH-2:0], 1'b0};
                alu_c   = x[M];
            end
            3'b110: begin
                alu_res = {1'b0, x[WIDTH-1:1]};
                alu_c   = x[0];
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        done_res = alu_res;
        done_c   = alu_c;
        done_v   = alu_v;
        if (state == MUL) begin
            done_res = acc_sum[WIDTH-1:0];
            done_c   = |acc_sum[2*WIDTH-1:WIDTH];
            done_v   = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            opa          <= '0;
            opb          <= '0;
            op_q         <= '0;
            cnt          <= '0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            carry        <= 1'b0;
            zero         <= 1'b0;
            negative     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            result_valid <= complete;
            if (accept) begin
                opa  <= {{WIDTH{1'b0}}, a};
                opb  <= b;
                op_q <= op;
                cnt  <= '0;
                acc  <= '0;
            end else if (state == MUL) begin
                acc <= acc_sum;
                opa <= opa << 1;
                opb <= opb >> 1;
                cnt <= cnt + CW'(1);
            end
            if (complete) begin
                result   <= done_res;
                carry    <= done_c;
                overflow <= done_v;
                zero     <= (done_res == '0);
                negative <= done_res[M];
            end
        end
    end

endmodule
